turn_controller: RTL
====================

# turn_controller

Sequences one player turn of the memory card game: takes select-button presses and the cursor position, fetches the two chosen card values from card memory, compares them, and maintains the face-up/matched board state. A mismatch stays visible for a hold period before flipping back. Sits between the button/cursor logic and the VGA board renderer, which reads `faceUp`, `matched` and `GO`.

## Interface
- `NUM_CARDS`, 36: board positions 0..35 (6x6).
- `NUM_PAIRS`, 18: pairs required for game over.
- `HOLD_CYCLES`, 50_000_000: mismatch display time in clocks (1 s at 50 MHz); must be ≥1.
- `PLAY_STATE`, 3'd2: value of `inputState` meaning "game in play".

- `clock`  in  1  system clock; all logic on rising edge.
- `resetN`  in  1  synchronous, active-low reset.
- `A`  in  1  select button, debounced and synchronous; level signal.
- `inputState`  in  3  top-level game mode; the controller acts only when it equals `PLAY_STATE`.
- `mem6x6`  in  6  cursor position, 0..63 encoded; valid range 0..35.
- `cardData`  in  5  card value at `rdAddr`; must be valid one cycle after `rdAddr` changes.
- `rdAddr`  out  6  card-memory read address, registered.
- `data1`, `data2`  out  5 each  captured values of first and second pick.
- `faceUp`  out  36  bit i = card i currently shown (includes matched cards).
- `matched`  out  36  bit i = card i permanently removed/matched.
- `pairsFound`  out  5  matched pair count, 0..18.
- `busy`  out  1  high in LOAD1, LOAD2, COMPARE, HOLD.
- `GO`  out  1  game over, high in DONE.

## Operation
- Press event: `A`=1 at a clock edge while registered `aPrev`=0. `aPrev` updates every cycle.
- Valid pick: `mem6x6`≤35, `matched[mem6x6]`=0, `faceUp[mem6x6]`=0. The last condition rejects re-picking the first card. Invalid presses are ignored, with no state change.
- States:
  - PICK1 → on valid press: `pick1`←`mem6x6`, `rdAddr`←`mem6x6`, set `faceUp[mem6x6]`; go to LOAD1.
  - LOAD1 (1 cycle) → `data1`←`cardData`; go to PICK2.
  - PICK2 → on valid press: `pick2`←`mem6x6`, `rdAddr`←`mem6x6`, set `faceUp[mem6x6]`; go to LOAD2.
  - LOAD2 (1 cycle) → `data2`←`cardData`; go to COMPARE.
  - COMPARE (1 cycle) → on `data1`==`data2`:
    - set `matched[pick1]` and `matched[pick2]`;
    - `pairsFound`+1;
    - go to DONE if the new count equals `NUM_PAIRS`, else PICK1.
  - COMPARE → on `data1`≠`data2`: load hold counter with `HOLD_CYCLES-1`; go to HOLD.
  - HOLD → counter decrements each cycle. At 0: clear `faceUp[pick1]` and `faceUp[pick2]`, go to PICK1.
  - DONE → `GO`=1. Holds until reset; all presses ignored.
- Presses in LOAD1, LOAD2, COMPARE, HOLD and DONE are dropped, not queued.
- `inputState`≠`PLAY_STATE` in any state except DONE:
  - next edge returns to PICK1;
  - clears `faceUp` bits not set in `matched`;
  - hold counter cleared;
  - `matched`, `pairsFound` and `data1`/`data2` retained.
  - Presses are ignored while not in play.
- `pairsFound` saturates at `NUM_PAIRS` and never wraps.

## Timing
- Reset (`resetN`=0 at an edge) takes priority over everything, including mid-HOLD and DONE. Reset values:
  - state PICK1, `aPrev`=0, `rdAddr`=0, `data1`=`data2`=0;
  - `faceUp`=0, `matched`=0, `pairsFound`=0, `busy`=0, `GO`=0, hold counter 0.
- Press accepted at edge k:
  - `rdAddr`/`faceUp` update at k;
  - `data1` valid after k+1;
  - PICK2 entered at k+1.
- Second press accepted at edge m:
  - `data2` after m+1;
  - COMPARE at m+1, result applied at m+2.
- Match: `matched`/`pairsFound` update at m+2; PICK1 (or DONE with `GO`=1) from m+2.
- Mismatch: HOLD entered at m+2. `faceUp` bits clear at m+2+`HOLD_CYCLES`, which is also when PICK1 is re-entered.
- A held `A` yields exactly one press; a new press requires `A` low for at least one edge.
- Outputs are all registered; no combinational input-to-output paths.

## Test plan
- Match: `cardData` model with pos0=pos18=5'b01111. Press at 0, then at 18 → `data1`=`data2`=15, `matched` bits 0,18 set, `pairsFound`=1, `faceUp` bits 0,18 remain 1, back in PICK1.
- Mismatch (`HOLD_CYCLES`=4): pos3=2, pos7=9. Press 3, then 7 → `busy`=1 for 1+1+4 cycles after second press. `faceUp` bits 3,7 return to 0 exactly 4 cycles after HOLD entry; `pairsFound` unchanged.
- Rejected picks:
  - press 5 then 5 again → second ignored, still PICK2;
  - `mem6x6`=40 → ignored;
  - press on a matched card → ignored.
- Held button / busy drop: `A` held high for 10 cycles → one pick only. Press during HOLD → no effect after HOLD ends.
- Game over: 18 matching pairs in sequence → `pairsFound`=18, `GO`=1. Further presses do not change `faceUp`, and `pairsFound` stays at 18.
- Abort and reset:
  - `inputState`→0 in PICK2 → next edge PICK1, unmatched `faceUp` bit cleared, `matched` kept;
  - `resetN`=0 during HOLD → all outputs zero at that edge.

Source files
------------

// File: rtl/turn_controller_if.sv
// Board bus between the turn controller and its neighbours.
// Master side: button/cursor logic, card memory. Slave side: turn_controller.
interface turn_controller_if #(
    parameter int NUM_CARDS = 36
);
    logic                 A;
    logic [2:0]           inputState;
    logic [5:0]           mem6x6;
    logic [4:0]           cardData;
    logic [5:0]           rdAddr;
    logic [4:0]           data1;
    logic [4:0]           data2;
    logic [NUM_CARDS-1:0] faceUp;
    logic [NUM_CARDS-1:0] matched;
    logic [4:0]           pairsFound;
    logic                 busy;
    logic                 GO;

    modport master (
        output A, inputState, mem6x6, cardData,
        input  rdAddr, data1, data2, faceUp, matched,
        input  pairsFound, busy, GO
    );

    modport slave (
        input  A, inputState, mem6x6, cardData,
        output rdAddr, data1, data2, faceUp, matched,
        output pairsFound, busy, GO
    );
endinterface

// File: rtl/turn_controller.sv
// Memory-game turn sequencer: two picks, fetch, compare, hold, board state.
// Ports: clock, resetN (sync active-low), bus (slave side of turn_controller_if).
module turn_controller #(
    parameter int         NUM_CARDS   = 36,
    parameter int         NUM_PAIRS   = 18,
    parameter int         HOLD_CYCLES = 50_000_000,
    parameter logic [2:0] PLAY_STATE  = 3'd2
) (
    input  logic              clock,
    input  logic              resetN,
    turn_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        S_PICK1,
        S_LOAD1,
        S_PICK2,
        S_LOAD2,
        S_COMPARE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [NUM_CARDS-1:0] ONE = NUM_CARDS'(1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [4:0] PAIRS_MAX = 5'(NUM_PAIRS);

    state_t               state_q, state_d;
    logic                 a_prev_q, a_prev_d;
    logic [5:0]           rd_addr_q, rd_addr_d;
    logic [4:0]           data1_q, data1_d;
    logic [4:0]           data2_q, data2_d;
    logic [5:0]           pick1_q, pick1_d;
    logic [5:0]           pick2_q, pick2_d;
    logic [NUM_CARDS-1:0] face_q, face_d;
    logic [NUM_CARDS-1:0] match_q, match_d;
    logic [4:0]           pairs_q, pairs_d;
    logic [CW-1:0]        hold_q, hold_d;
    logic                 busy_q, busy_d;
    logic                 go_q, go_d;

    logic                 press;
    logic                 in_play;
    logic                 abort;
    logic                 pos_ok;
    logic [NUM_CARDS-1:0] sel_cur;
    logic [NUM_CARDS-1:0] sel_p1;
    logic [NUM_CARDS-1:0] sel_p2;
    logic                 occupied;
    logic                 pick_ok;
    logic                 same;
    logic                 hold_zero;
    logic [4:0]           pairs_inc;
    logic                 last_pair;

    // Rising edge of the level-type button; held A yields one event.
    assign press     = bus.A & ~a_prev_q;
    assign in_play   = (bus.inputState == PLAY_STATE);
    // Leaving play aborts the turn everywhere except after game over.
    assign abort     = ~in_play & (state_q != S_DONE);
    assign pos_ok    = (int'(bus.mem6x6) < NUM_CARDS);
    // Out-of-range cursor shifts the one-hot off the board (all zero).
    assign sel_cur   = ONE << bus.mem6x6;
    assign sel_p1    = ONE << pick1_q;
    assign sel_p2    = ONE << pick2_q;
    // faceUp covers the first pick, so re-picking it is rejected here.
    assign occupied  = |(sel_cur & (face_q | match_q));
    assign pick_ok   = press & pos_ok & ~occupied;
    assign same      = (data1_q == data2_q);
    assign hold_zero = (hold_q == '0);
    assign pairs_inc = (pairs_q < PAIRS_MAX) ? pairs_q + 5'd1 : pairs_q;
    assign last_pair = (pairs_inc == PAIRS_MAX);

    // State register
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q <= S_PICK1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_PICK1;
        end else begin
            unique case (state_q)
                S_PICK1:   if (pick_ok) state_d = S_LOAD1;
                S_LOAD1:   state_d = S_PICK2;
                S_PICK2:   if (pick_ok) state_d = S_LOAD2;
                S_LOAD2:   state_d = S_COMPARE;
                S_COMPARE: begin
                    if (!same)          state_d = S_HOLD;
                    else if (last_pair) state_d = S_DONE;
                    else                state_d = S_PICK1;
                end
                S_HOLD:    if (hold_zero) state_d = S_PICK1;
                S_DONE:    state_d = S_DONE;
                default:   state_d = S_PICK1;
            endcase
        end
    end

    // Output and datapath next-state logic
    always_comb begin
        a_prev_d  = bus.A;
        rd_addr_d = rd_addr_q;
        data1_d   = data1_q;
        data2_d   = data2_q;
        pick1_d   = pick1_q;
        pick2_d   = pick2_q;
        face_d    = face_q;
        match_d   = match_q;
        pairs_d   = pairs_q;
        hold_d    = hold_q;
        if (abort) begin
            face_d = face_q & match_q;
            hold_d = '0;
        end else begin
            unique case (state_q)
                S_PICK1: begin
                    if (pick_ok) begin
                        pick1_d   = bus.mem6x6;
                        rd_addr_d = bus.mem6x6;
                        face_d    = face_q | sel_cur;
                    end
                end
                S_LOAD1: data1_d = bus.cardData;
                S_PICK2: begin
                    if (pick_ok) begin
                        pick2_d   = bus.mem6x6;
                        rd_addr_d = bus.mem6x6;
                        face_d    = face_q | sel_cur;
                    end
                end
                S_LOAD2: data2_d = bus.cardData;
                S_COMPARE: begin
                    if (same) begin
                        match_d = match_q | sel_p1 | sel_p2;
                        pairs_d = pairs_inc;
                    end else begin
                        hold_d = HOLD_LOAD;
                    end
                end
                S_HOLD: begin
                    if (hold_zero) begin
                        face_d = face_q & ~(sel_p1 | sel_p2);
                    end else begin
                        hold_d = hold_q - CW'(1);
                    end
                end
                S_DONE:  ;
                default: ;
            endcase
        end
        // Status flags registered from the upcoming state.
        busy_d = (state_d == S_LOAD1) || (state_d == S_LOAD2) ||
                 (state_d == S_COMPARE) || (state_d == S_HOLD);
        go_d   = (state_d == S_DONE);
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (!resetN) begin
            a_prev_q  <= 1'b0;
            rd_addr_q <= '0;
            data1_q   <= '0;
            data2_q   <= '0;
            pick1_q   <= '0;
            pick2_q   <= '0;
            face_q    <= '0;
            match_q   <= '0;
            pairs_q   <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            go_q      <= 1'b0;
        end else begin
            a_prev_q  <= a_prev_d;
            rd_addr_q <= rd_addr_d;
            data1_q   <= data1_d;
            data2_q   <= data2_d;
            pick1_q   <= pick1_d;
            pick2_q   <= pick2_d;
            face_q    <= face_d;
            match_q   <= match_d;
            pairs_q   <= pairs_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            go_q      <= go_d;
        end
    end

    assign bus.rdAddr     = rd_addr_q;
    assign bus.data1      = data1_q;
    assign bus.data2      = data2_q;
    assign bus.faceUp     = face_q;
    assign bus.matched    = match_q;
    assign bus.pairsFound = pairs_q;
    assign bus.busy       = busy_q;
    assign bus.GO         = go_q;

endmodule
